wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Writeback-side consumer of the W-stage pipeline register outputs (read_data_w, alu_result_w, result_src_w, reg_write_w, rd_w, pc_plus4_w).
- Selects the final result and commits it to the architectural 32x32 integer register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Exports the selected result and destination for the hazard/forwarding unit.

Parameters:
- XLEN, 32, data width of registers and results.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- AW, 5, register index width; must satisfy 2**AW == NREGS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- read_data_w  input  XLEN  load data from the W-stage register.
- alu_result_w  input  XLEN  ALU result from the W-stage register.
- result_src_w  input  2  result select: 00 ALU, 01 load data, 10 pc_plus4, 11 reserved.
- reg_write_w  input  1  writeback enable.
- rd_w  input  AW  destination register index.
- pc_plus4_w  input  XLEN  link value from the W-stage register.
- rs1_d  input  AW  decode read index, port 1.
- rs2_d  input  AW  decode read index, port 2.
- rd1_d  output  XLEN  read data, port 1.
- rd2_d  output  XLEN  read data, port 2.
- result_w  output  XLEN  selected writeback value, to the forwarding unit.
- fwd_valid_w  output  1  high when reg_write_w=1 and rd_w!=0.
- retire_cnt  output  64  count of committed register writes; see Optional Feature.

Behaviour:
- Reset is asynchronous and active-high. While rst=1, all NREGS entries clear to 0 and retire_cnt clears to 0. Combinational outputs follow from that cleared state.
- Reset can assert mid-operation: it clears state immediately, not at the next edge. Any write presented in the same cycle is discarded.
- result_w is combinational:
  - 00 gives alu_result_w.
  - 01 gives read_data_w.
  - 10 gives pc_plus4_w.
  - 11 gives 0. The write still occurs if enabled.
- Write: on a rising edge with rst=0, reg_write_w=1 and rd_w!=0, regs[rd_w] <= result_w. Writes to x0 are dropped silently.
- Read ports are combinational, with zero-cycle latency from rs*_d.
- rdN_d is 0 when rsN_d=0.
- Bypass: when fwd_valid_w=1 and rsN_d==rd_w, rdN_d=result_w, so the same-cycle write is visible. Otherwise rdN_d=regs[rsN_d].
- Both ports may read the same index at once, and both may hit the bypass in the same cycle. Each port is independent.
- fwd_valid_w = reg_write_w & (rd_w!=0), purely combinational.
- The block has no stall or flush inputs. Bubbles arrive as reg_write_w=0 from the upstream register.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 on each edge where a write commits (fwd_valid_w=1, rst=0). It wraps from 2^64-1 to 0 and is async-cleared by rst.
- Undefined: retire_cnt is tied to 0, no counter flops are built, and the port stays present so the interface is stable.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN and the AW localparam.
  - result_src_e enum: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_RSVD=2'b11.
- One natural sub-module, wb_result_mux: the combinational 4:1 result select, reusable by the forwarding unit.
- Register array and bypass stay in wb_regfile.

Test Plan:
- Reset: pulse rst between edges. All of rd1_d and rd2_d read 0 for rs=0..31 immediately, without waiting for a clock, and retire_cnt reads 0.
- Basic write/read: alu_result_w=0xDEADBEEF, result_src_w=00, rd_w=5, reg_write_w=1, one edge, then rs1_d=5 gives rd1_d=0xDEADBEEF. Repeat with src 01/read_data=0x12345678 and src 10/pc_plus4=0x1004 on x6 and x7.
- Bypass: regs[9]=0x11. Present a write of 0x22 to x9, with rs1_d=rs2_d=9 in the same cycle, so rd1_d=rd2_d=0x22 before the edge. With reg_write_w=0 the same setup reads 0x11.
- x0 protection: write 0xFFFFFFFF to rd_w=0 gives fwd_valid_w=0 and rd1_d(rs=0)=0 after the edge; with WB_RETIRE_CNT_EN, retire_cnt is unchanged.
- Reserved select: result_src_w=11, rd_w=3, reg_write_w=1 gives result_w=0 and x3=0 after the edge.
- Mid-operation reset and counter: with WB_RETIRE_CNT_EN, 10 valid writes give retire_cnt=10. Assert rst asynchronously during an active write: the counter and all regs are 0, and the pending write is not committed after rst deasserts.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and result-select encoding for the writeback stage
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

endpackage

// File: rtl/wb_result_mux.sv
// rtl/wb_result_mux.sv - combinational 4:1 writeback result select
module wb_result_mux
  import cpu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] read_data,
  input  logic [W-1:0] pc_plus4,
  output logic [W-1:0] result
);

  always_comb begin
    result = '0;
    case (sel)
      RES_ALU:  result = alu_result;
      RES_MEM:  result = read_data;
      RES_PC4:  result = pc_plus4;
      RES_RSVD: result = '0;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback result select, 32x32 register file with bypass; WB_RETIRE_CNT_EN adds a retire counter
module wb_regfile #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int NREGS = cpu_pkg::NREGS,
  parameter int AW    = cpu_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] read_data_w,
  input  logic [XLEN-1:0] alu_result_w,
  input  logic [1:0]      result_src_w,
  input  logic            reg_write_w,
  input  logic [AW-1:0]   rd_w,
  input  logic [XLEN-1:0] pc_plus4_w,
  input  logic [AW-1:0]   rs1_d,
  input  logic [AW-1:0]   rs2_d,
  output logic [XLEN-1:0] rd1_d,
  output logic [XLEN-1:0] rd2_d,
  output logic [XLEN-1:0] result_w,
  output logic            fwd_valid_w,
  output logic [63:0]     retire_cnt
);

  logic [XLEN-1:0] regs [NREGS];

  wb_result_mux #(.W(XLEN)) u_result_mux (
    .sel        (result_src_w),
    .alu_result (alu_result_w),
    .read_data  (read_data_w),
    .pc_plus4   (pc_plus4_w),
    .result     (result_w)
  );

  assign fwd_valid_w = reg_write_w && (rd_w != '0);

  // regs[0] is never written because fwd_valid_w excludes rd_w == 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (fwd_valid_w) begin
      regs[rd_w] <= result_w;
    end
  end

  assign rd1_d = (rs1_d == '0)                   ? '0       :
                 (fwd_valid_w && rs1_d == rd_w)  ? result_w : regs[rs1_d];
  assign rd2_d = (rs2_d == '0)                   ? '0       :
                 (fwd_valid_w && rs2_d == rd_w)  ? result_w : regs[rs2_d];

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= '0;
    end else if (fwd_valid_w) begin
      retire_q <= retire_q + 64'd1;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = '0;
`endif

endmodule
